sram_mem_responder: RTL and testbench
=====================================

Name: sram_mem_responder

Overview:
- Responder end of the MEM-stage data-memory interface: serves the pipeline's 32-bit load/store requests (MEM_R_EN/MEM_W_EN, ALU-result address, Val_Rm write data) against a 16-bit external SRAM.
- Each word takes two half-word accesses, with programmable wait states per half.
- Drops `ready` while busy; the top level ORs `~ready` into the pipeline freeze.

Parameters:
- WAIT_CYCLES, 5, cycles spent in each half-word phase, including one address-setup cycle; legal range 2..15.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_r_en  in  1  load request; held stable until ready=1.
- mem_w_en  in  1  store request; held stable until ready=1.
- address  in  32  byte address from ALU result.
- wdata  in  32  store data (Val_Rm).
- rdata  out  32  load result, registered.
- ready  out  1  request complete / responder idle.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to SRAM.
- sram_dq_in  in  16  read data from SRAM.
- sram_dq_oe  out  1  1 = drive DQ bus (write).
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=IDLE, counter=0, rdata=0.
  - sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
  - ready=1 while mem_r_en=mem_w_en=0.
- Reset mid-access aborts immediately. The half already strobed may be written; no further SRAM writes occur.
- Address mapping:
  - word = (address - BASE_ADDR) >> 2, modulo 2^32; address[1:0] ignored.
  - Half-word addresses are {word[SRAM_AW-2:0],1'b0} for the low half and {word[SRAM_AW-2:0],1'b1} for the high half.
  - Upper bits are truncated, so accesses wrap.
- States: IDLE, LOW, HIGH, DONE.
  - IDLE: if mem_w_en or mem_r_en, latch op, mapped address and wdata; go to LOW with counter=0. If both are asserted, the write wins.
  - LOW: counter increments each cycle; on counter==WAIT_CYCLES-1, go to HIGH with counter=0.
  - HIGH: same counting; on counter==WAIT_CYCLES-1, go to DONE.
  - DONE: one cycle, then IDLE unconditionally.
- ready = (IDLE and no request) or DONE. It is combinational from state and requests and is never high in LOW or HIGH.
- Latency: a request first seen in IDLE at cycle 0 gives ready=1 in cycle 2*WAIT_CYCLES+1 (cycle 11 at default). The pipeline advances at the end of that cycle.
- A new request present in the cycle after DONE starts a fresh access. The DONE cycle itself never restarts.
- Write phases:
  - sram_dq_oe=1 throughout LOW and HIGH.
  - sram_dq_out = wdata[15:0] in LOW, wdata[31:16] in HIGH.
  - sram_we_n=0 for every cycle of the phase except counter==0 (address setup).
- Read phases:
  - sram_dq_oe=0 and sram_we_n=1.
  - sram_dq_in is captured on the last cycle of LOW into rdata[15:0] and on the last cycle of HIGH into rdata[31:16].
  - rdata is stable in DONE and held until the next read updates it. Writes never modify rdata.
- sram_addr holds the low-half address in LOW, the high-half address in HIGH, and its last value in IDLE/DONE.
- Request inputs are sampled only in IDLE; changes during LOW/HIGH are ignored because the latched copy is used.

Test Plan:
- Reset asserted asynchronously mid-cycle -> outputs immediately show rdata=0, sram_we_n=1, sram_dq_oe=0, ready=1, with no clock edge required.
- Store address=1024+8, wdata=0xDEADBEEF, W=5 ->
  - sram_addr=4 for 5 cycles with dq_out=0xBEEF and we_n low in cycles 2-5 of the phase.
  - Then sram_addr=5 with dq_out=0xDEAD.
  - ready=1 exactly in cycle 11; SRAM model holds the word.
- Load same address, model returns stored halves -> rdata=0xDEADBEEF in cycle 11; we_n stays 1 throughout; rdata is held after mem_r_en deasserts.
- Back-to-back store then load issued the cycle after DONE -> second access starts with no idle gap; each completes in 11 cycles; no double write.
- mem_r_en and mem_w_en both high, address=1020 -> treated as a write to wrapped word 0x3FFFFFFF; sram_addr low half = 0x3FFFE (SRAM_AW=18).
- Reset pulsed during the HIGH phase of a write -> state returns to IDLE, we_n=1 immediately, high half not written; the next request completes normally in 11 cycles.

Source files
------------

// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: serves 32-bit loads/stores as two 16-bit
// SRAM half-word accesses, each phase lasting WAIT_CYCLES cycles.
module sram_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [31:0]      BASE     = 32'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e              state_q,  state_d;
    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    logic                is_wr_q,  is_wr_d;
    logic [WORD_W-1:0]   word_q,   word_d;
    logic [31:0]         wdata_q,  wdata_d;
    logic [31:0]         rdata_q,  rdata_d;
    logic [SRAM_AW-1:0]  addr_q,   addr_d;
    logic [15:0]         dq_out_q, dq_out_d;
    logic                dq_oe_q,  dq_oe_d;
    logic                we_n_q,   we_n_d;

    logic [WORD_W-1:0]   req_word;
    logic                phase_last;
    logic                in_phase_d;

    // Word index relative to BASE_ADDR; upper bits drop so accesses wrap.
    assign req_word   = WORD_W'((address - BASE) >> 2);
    assign phase_last = (cnt_q == CNT_LAST);

    // Sequencing: latch the request in IDLE, then count out LOW and HIGH.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (mem_w_en || mem_r_en) begin
                    state_d = LOW;
                    cnt_d   = '0;
                    is_wr_d = mem_w_en;
                    word_d  = req_word;
                    wdata_d = wdata;
                end
            end
            LOW: begin
                if (phase_last) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!is_wr_q) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // SRAM pins are registered, so they are derived from the next state.
    always_comb begin
        addr_d     = addr_q;
        dq_out_d   = dq_out_q;
        dq_oe_d    = 1'b0;
        we_n_d     = 1'b1;
        in_phase_d = (state_d == LOW) || (state_d == HIGH);
        if (state_d == LOW) begin
            addr_d = {word_d, 1'b0};
        end else if (state_d == HIGH) begin
            addr_d = {word_d, 1'b1};
        end
        if (is_wr_d && in_phase_d) begin
            dq_oe_d  = 1'b1;
            we_n_d   = (cnt_d == '0);
            dq_out_d = (state_d == HIGH) ? wdata_d[31:16] : wdata_d[15:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_wr_q  <= 1'b0;
            word_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            addr_q   <= '0;
            dq_out_q <= '0;
            dq_oe_q  <= 1'b0;
            we_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dq_out_q <= dq_out_d;
            dq_oe_q  <= dq_oe_d;
            we_n_q   <= we_n_d;
        end
    end

    // ready feeds the pipeline freeze directly, hence combinational.
    assign ready       = ((state_q == IDLE) && !mem_r_en && !mem_w_en) || (state_q == DONE);
    assign rdata       = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: transaction-level memory model plus an
// SRAM model on the pins; every access is checked cycle by cycle.
module tb_sram_mem_responder;

    localparam int W     = 5;
    localparam int BASE  = 1024;
    localparam int SAW   = 18;
    localparam int LAT   = 2 * W + 1;
    localparam int DEPTH = 1 << SAW;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           mem_r_en = 1'b0;
    logic           mem_w_en = 1'b0;
    logic [31:0]    address = '0;
    logic [31:0]    wdata = '0;
    logic [31:0]    rdata;
    logic           ready;
    logic [SAW-1:0] sram_addr;
    logic [15:0]    sram_dq_out;
    logic [15:0]    sram_dq_in;
    logic           sram_dq_oe;
    logic           sram_we_n;

    sram_mem_responder #(
        .WAIT_CYCLES(W),
        .BASE_ADDR  (BASE),
        .SRAM_AW    (SAW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .address    (address),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_in (sram_dq_in),
        .sram_dq_oe (sram_dq_oe),
        .sram_we_n  (sram_we_n)
    );

    always #5 clk = ~clk;

    // External SRAM: asynchronous read, write on each clock with we_n low.
    logic [15:0] sram [0:DEPTH-1] = '{default: 16'h0};
    assign sram_dq_in = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
    end

    int wr_pulses = 0;
    always @(negedge sram_we_n) wr_pulses <= wr_pulses + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]    ref_mem [logic [SAW-1:0]];
    logic [31:0]    ref_rdata = '0;
    logic [SAW-1:0] obs_lo;

    function automatic void map_addr(input logic [31:0] a, output logic [SAW-1:0] lo,
                                     output logic [SAW-1:0] hi);
        logic [31:0] off;
        logic [31:0] word;
        off  = a - 32'(BASE);
        word = off / 4;
        lo   = SAW'((word % (32'd1 << (SAW - 1))) * 2);
        hi   = SAW'(lo + 1);
    endfunction

    function automatic logic [15:0] ref_get(input logic [SAW-1:0] h);
        if (ref_mem.exists(h)) return ref_mem[h];
        return 16'h0;
    endfunction

    task automatic do_access(input bit wr, input bit rd, input logic [31:0] a,
                             input logic [31:0] d, input bit scramble);
        logic [SAW-1:0] lo, hi, exp_addr;
        logic [31:0]    exp_r;
        int             p0, c;
        bit             in_hi;
        map_addr(a, lo, hi);
        exp_r = wr ? ref_rdata : {ref_get(hi), ref_get(lo)};
        @(posedge clk); #1;
        mem_w_en = wr; mem_r_en = rd; address = a; wdata = d;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b0) begin
            n_fail++; $display("FAIL ready_cycle0 a=%h: got %b expected 0", a, ready);
        end
        p0 = wr_pulses;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            if (scramble) begin address = $urandom; wdata = $urandom; end
            @(negedge clk);
            n_tests++;
            if (ready !== 1'(k == LAT)) begin
                n_fail++; $display("FAIL ready cycle %0d a=%h: got %b expected %b", k, a, ready, k == LAT);
            end
            if (k < LAT) begin
                in_hi    = (k > W);
                c        = in_hi ? k - W - 1 : k - 1;
                exp_addr = in_hi ? hi : lo;
                if (k == 1) obs_lo = sram_addr;
                n_tests++;
                if (sram_addr !== exp_addr) begin
                    n_fail++; $display("FAIL sram_addr cycle %0d: got %h expected %h", k, sram_addr, exp_addr);
                end
                n_tests++;
                if (sram_dq_oe !== 1'(wr)) begin
                    n_fail++; $display("FAIL dq_oe cycle %0d: got %b expected %b", k, sram_dq_oe, wr);
                end
                n_tests++;
                if (sram_we_n !== !(wr && c != 0)) begin
                    n_fail++; $display("FAIL we_n cycle %0d: got %b expected %b", k, sram_we_n, !(wr && c != 0));
                end
                if (wr) begin
                    n_tests++;
                    if (sram_dq_out !== (in_hi ? d[31:16] : d[15:0])) begin
                        n_fail++; $display("FAIL dq_out cycle %0d: got %h expected %h", k, sram_dq_out,
                                           in_hi ? d[31:16] : d[15:0]);
                    end
                end
            end else begin
                n_tests++;
                if (rdata !== exp_r) begin
                    n_fail++; $display("FAIL rdata_done a=%h wr=%b: got %h expected %h", a, wr, rdata, exp_r);
                end
                n_tests++;
                if (sram_addr !== hi) begin
                    n_fail++; $display("FAIL sram_addr_done: got %h expected %h", sram_addr, hi);
                end
                if (wr) begin
                    n_tests++;
                    if (wr_pulses - p0 !== 2) begin
                        n_fail++; $display("FAIL write_pulses a=%h: got %0d expected 2", a, wr_pulses - p0);
                    end
                    n_tests++;
                    if ({sram[hi], sram[lo]} !== d) begin
                        n_fail++; $display("FAIL sram_contents a=%h: got %h expected %h", a, {sram[hi], sram[lo]}, d);
                    end
                end
            end
        end
        if (wr) begin
            ref_mem[lo] = d[15:0];
            ref_mem[hi] = d[31:16];
        end else begin
            ref_rdata = exp_r;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        mem_w_en = 1'b0; mem_r_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            n_tests++;
            if (ready !== 1'b1 || sram_we_n !== 1'b1) begin
                n_fail++; $display("FAIL idle_pins: got ready=%b we_n=%b expected 1/1", ready, sram_we_n);
            end
            n_tests++;
            if (rdata !== ref_rdata) begin
                n_fail++; $display("FAIL rdata_hold: got %h expected %h", rdata, ref_rdata);
            end
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({rdata, sram_addr, sram_dq_out} !== '0 || sram_dq_oe !== 1'b0 ||
            sram_we_n !== 1'b1 || ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_state: got rdata=%h addr=%h dq=%h oe=%b we_n=%b ready=%b expected 0/0/0/0/1/1",
                               rdata, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle(2);
    endtask

    task automatic test_store_load;
        do_access(1'b1, 1'b0, 32'(BASE + 8), 32'hDEAD_BEEF, 1'b0);
        n_tests++;
        if (obs_lo !== 18'd4) begin
            n_fail++; $display("FAIL store_low_addr: got %h expected 4", obs_lo);
        end
        idle(2);
        do_access(1'b0, 1'b1, 32'(BASE + 8), 32'h0, 1'b0);
        idle(3);
        n_tests++;
        if (rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL load_value_held: got %h expected deadbeef", rdata);
        end
    endtask

    task automatic test_back_to_back;
        do_access(1'b1, 1'b0, 32'(BASE + 64), 32'h1234_5678, 1'b0);
        do_access(1'b0, 1'b1, 32'(BASE + 64), 32'h0, 1'b0);
        do_access(1'b1, 1'b0, 32'(BASE + 68), 32'hCAFE_F00D, 1'b1);
        do_access(1'b1, 1'b0, 32'(BASE + 64), 32'h0BAD_5EED, 1'b0);
        do_access(1'b0, 1'b1, 32'(BASE + 68), 32'h0, 1'b1);
        do_access(1'b0, 1'b1, 32'(BASE + 64), 32'h0, 1'b0);
        idle(2);
    endtask

    task automatic test_both_wrap;
        do_access(1'b1, 1'b1, 32'd1020, 32'hA5A5_3C3C, 1'b0);
        n_tests++;
        if (obs_lo !== 18'h3FFFE) begin
            n_fail++; $display("FAIL wrap_low_addr: got %h expected 3fffe", obs_lo);
        end
        do_access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b0);
        idle(1);
    endtask

    task automatic test_reset_mid_write(input int kr, input logic [31:0] a, input logic [31:0] d);
        logic [SAW-1:0] lo, hi;
        logic [15:0]    old_hi;
        int             c;
        map_addr(a, lo, hi);
        old_hi = ref_get(hi);
        c = (kr <= W) ? kr - 1 : kr - W - 1;
        @(posedge clk); #1;
        mem_w_en = 1'b1; mem_r_en = 1'b0; address = a; wdata = d;
        for (int k = 1; k <= kr; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        n_tests++;
        if (sram_we_n !== 1'(c == 0)) begin
            n_fail++; $display("FAIL pre_reset_we_n: got %b expected %b", sram_we_n, c == 0);
        end
        #2;
        reset = 1'b1; mem_w_en = 1'b0;
        #1;
        n_tests++;
        if (rdata !== 32'h0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1) begin
            n_fail++; $display("FAIL async_reset kr=%0d: got rdata=%h we_n=%b oe=%b ready=%b expected 0/1/0/1",
                               kr, rdata, sram_we_n, sram_dq_oe, ready);
        end
        n_tests++;
        if (sram_addr !== '0 || sram_dq_out !== '0) begin
            n_fail++; $display("FAIL async_reset_bus kr=%0d: got addr=%h dq=%h expected 0/0", kr, sram_addr, sram_dq_out);
        end
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        ref_rdata   = 32'h0;
        ref_mem[lo] = d[15:0];
        @(negedge clk);
        n_tests++;
        if (sram[hi] !== old_hi || sram[lo] !== d[15:0]) begin
            n_fail++; $display("FAIL aborted_write kr=%0d: got hi=%h lo=%h expected hi=%h lo=%h",
                               kr, sram[hi], sram[lo], old_hi, d[15:0]);
        end
        do_access(1'b0, 1'b1, a, 32'h0, 1'b0);
        idle(1);
    endtask

    task automatic test_random;
        logic [31:0] a, d;
        int          op;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else a = 32'(BASE) + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            do_access(op != 1, op != 0, a, d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_both_wrap();
        test_reset_mid_write(W + 1, 32'(BASE + 8), 32'h7777_1111);
        test_reset_mid_write(3, 32'(BASE + 200), 32'h4242_9999);
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
